// File: rtl/wasm_imm_decoder_pkg.sv
// Shared encodings for the bytecode immediate decoder: operand kinds, FSM states
// and the maximum LEB128 lengths.
package wasm_imm_decoder_pkg;

  typedef enum logic [2:0] {
    IMM_ULEB32 = 3'd0,
    IMM_SLEB32 = 3'd1,
    IMM_SLEB64 = 3'd2,
    IMM_FIX32  = 3'd3,
    IMM_FIX64  = 3'd4
  } imm_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_ACC   = 2'd2
  } state_e;

  localparam int MAX_LEB32_BYTES = 5;
  localparam int MAX_LEB64_BYTES = 10;

endpackage

// File: rtl/leb_sext.sv
// Sign extension for a signed LEB128 value whose last 7-bit group sits at 'shift'.
// The 32-bit flavour keeps the upper half zero, as the operand stack expects.
module leb_sext (
  input  logic [63:0] value,
  input  logic [6:0]  shift,
  input  logic        is64,
  output logic [63:0] ext
);

  logic [7:0]  sign_pos;
  logic [7:0]  fill_pos;
  logic        sign;
  logic [63:0] mask;
  logic [63:0] wide;

  always_comb begin
    sign_pos = {1'b0, shift} + 8'd6;
    fill_pos = {1'b0, shift} + 8'd7;
    sign     = (sign_pos < 8'd64) ? value[sign_pos[5:0]] : 1'b0;
    // Nothing left to fill once the last group reaches the top bit.
    mask     = (fill_pos < 8'd64) ? ({64{1'b1}} << fill_pos[5:0]) : 64'd0;
    wide     = sign ? (value | mask) : value;
    ext      = is64 ? wide : {32'd0, wide[31:0]};
  end

endmodule

// File: rtl/wasm_imm_decoder.sv
// Reads the immediate that follows an opcode from the synchronous bytecode ROM and
// decodes LEB128 or fixed little-endian operands into a 64-bit stack value.
module wasm_imm_decoder
  import wasm_imm_decoder_pkg::*;
#(
  parameter int ROM_ADDR = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          kind,
  input  logic [ROM_ADDR-1:0] pc_in,
  output logic [ROM_ADDR-1:0] rom_addr,
  input  logic [7:0]          rom_data,
  output logic [63:0]         result,
  output logic [ROM_ADDR-1:0] pc_out,
  output logic                busy,
  output logic                done,
  output logic                error
);

  state_e              state_q, state_d;
  imm_kind_e           kind_q, kind_d;
  logic [ROM_ADDR-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_ADDR-1:0] pc_start_q, pc_start_d;
  logic [ROM_ADDR-1:0] pc_out_q, pc_out_d;
  logic [63:0]         acc_q, acc_d;
  logic [63:0]         result_q, result_d;
  logic [3:0]          count_q, count_d;
  logic [6:0]          shift_q, shift_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [63:0]         leb_byte;
  logic [63:0]         fix_byte;
  logic [63:0]         sext_val;
  logic [ROM_ADDR-1:0] pc_next;
  logic                is_fix;
  logic                finish;

  leb_sext u_leb_sext (
    .value (acc_d),
    .shift (shift_q),
    .is64  (kind_q == IMM_SLEB64),
    .ext   (sext_val)
  );

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    rom_addr_d = rom_addr_q;
    pc_start_d = pc_start_q;
    pc_out_d   = pc_out_q;
    acc_d      = acc_q;
    result_d   = result_q;
    count_d    = count_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    finish     = 1'b0;

    leb_byte = {57'd0, rom_data[6:0]} << shift_q;
    fix_byte = {56'd0, rom_data} << {count_q[2:0], 3'b000};
    pc_next  = pc_start_q + ROM_ADDR'(count_q) + ROM_ADDR'(1);
    is_fix   = (kind_q == IMM_FIX32) || (kind_q == IMM_FIX64);

    unique case (state_q)
      ST_IDLE: begin
        // A start landing on the done cycle is dropped; the cpu retries from IDLE.
        if (start && !done_q) begin
          if (kind <= 3'd4) begin
            state_d    = ST_PRIME;
            kind_d     = imm_kind_e'(kind);
            rom_addr_d = pc_in;
            pc_start_d = pc_in;
            acc_d      = 64'd0;
            count_d    = 4'd0;
            shift_d    = 7'd0;
            busy_d     = 1'b1;
            error_d    = 1'b0;
          end else begin
            done_d   = 1'b1;
            error_d  = 1'b1;
            result_d = 64'd0;
            pc_out_d = pc_in;
          end
        end
      end

      ST_PRIME: begin
        rom_addr_d = rom_addr_q + ROM_ADDR'(1);
        state_d    = ST_ACC;
      end

      ST_ACC: begin
        rom_addr_d = rom_addr_q + ROM_ADDR'(1);
        count_d    = count_q + 4'd1;
        if (is_fix) begin
          acc_d = acc_q | fix_byte;
          if (count_q == ((kind_q == IMM_FIX32) ? 4'd3 : 4'd7)) begin
            finish   = 1'b1;
            result_d = (kind_q == IMM_FIX32) ? {32'd0, acc_d[31:0]} : acc_d;
          end
        end else begin
          acc_d   = acc_q | leb_byte;
          shift_d = shift_q + 7'd7;
          if (!rom_data[7]) begin
            finish   = 1'b1;
            result_d = (kind_q == IMM_ULEB32) ? {32'd0, acc_d[31:0]} : sext_val;
          end else if (count_q == ((kind_q == IMM_SLEB64) ? 4'(MAX_LEB64_BYTES - 1)
                                                          : 4'(MAX_LEB32_BYTES - 1))) begin
            finish   = 1'b1;
            error_d  = 1'b1;
            result_d = 64'd0;
          end
        end
        if (finish) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          pc_out_d = pc_next;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      kind_q     <= IMM_ULEB32;
      rom_addr_q <= '0;
      pc_start_q <= '0;
      pc_out_q   <= '0;
      acc_q      <= 64'd0;
      result_q   <= 64'd0;
      count_q    <= 4'd0;
      shift_q    <= 7'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      rom_addr_q <= rom_addr_d;
      pc_start_q <= pc_start_d;
      pc_out_q   <= pc_out_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign result   = result_q;
  assign pc_out   = pc_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_wasm_imm_decoder.sv
// Directed bench for the immediate decoder with a synchronous ROM model.
module tb_wasm_imm_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  kind = 3'd0;
  logic [7:0]  pc_in = 8'd0;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic [63:0] result;
  logic [7:0]  pc_out;
  logic        busy, done, error;

  logic [7:0]  mem [256];
  int checks = 0;
  int failures = 0;
  int de, bc;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  wasm_imm_decoder #(.ROM_ADDR(8)) dut (
    .clk(clk), .reset(reset), .start(start), .kind(kind), .pc_in(pc_in),
    .rom_addr(rom_addr), .rom_data(rom_data), .result(result), .pc_out(pc_out),
    .busy(busy), .done(done), .error(error)
  );

  // Pulses start, then reports the edge index (start edge = 0) at which done was
  // seen and how many sampled cycles had busy high. hammer re-asserts start while busy.
  task automatic run(input logic [2:0] k, input logic [7:0] pc, input bit hammer,
                     output int done_edge, output int busy_cyc);
    done_edge = -1;
    busy_cyc  = 0;
    repeat (2) @(negedge clk);
    start = 1'b1; kind = k; pc_in = pc;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) busy_cyc++;
    if (done) done_edge = 0;
    for (int e = 1; e <= 40 && done_edge < 0; e++) begin
      if (hammer) begin
        @(negedge clk);
        start = 1'b1; kind = 3'd3; pc_in = 8'd4;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) busy_cyc++;
      if (done) done_edge = e;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (pc_out !== 8'd0) begin failures++; $display("FAIL reset_pc_out got=%h exp=0", pc_out); end
    checks++; if (rom_addr !== 8'd0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
    checks++; if ({busy, done, error} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, error}); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_fix32();
    mem[4] = 8'h00; mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'hc0;
    run(3'd3, 8'd4, 1'b0, de, bc);
    checks++; if (de !== 5) begin failures++; $display("FAIL fix32_done_edge got=%0d exp=5", de); end
    checks++; if (bc !== 5) begin failures++; $display("FAIL fix32_busy_cycles got=%0d exp=5", bc); end
    checks++; if (result !== 64'h00000000c0000000) begin failures++; $display("FAIL fix32_result got=%h exp=00000000c0000000", result); end
    checks++; if (pc_out !== 8'd8) begin failures++; $display("FAIL fix32_pc_out got=%0d exp=8", pc_out); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL fix32_error got=%b exp=0", error); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL fix32_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_leb();
    mem[16] = 8'he5; mem[17] = 8'h8e; mem[18] = 8'h26;
    run(3'd0, 8'd16, 1'b0, de, bc);
    checks++; if (de !== 4) begin failures++; $display("FAIL uleb_done_edge got=%0d exp=4", de); end
    checks++; if (result !== 64'd624485) begin failures++; $display("FAIL uleb_result got=%h exp=%h", result, 64'd624485); end
    checks++; if (pc_out !== 8'd19) begin failures++; $display("FAIL uleb_pc_out got=%0d exp=19", pc_out); end
    mem[32] = 8'h7f;
    run(3'd1, 8'd32, 1'b0, de, bc);
    checks++; if (de !== 2) begin failures++; $display("FAIL sleb32_done_edge got=%0d exp=2", de); end
    checks++; if (result !== 64'h00000000ffffffff) begin failures++; $display("FAIL sleb32_result got=%h exp=00000000ffffffff", result); end
    mem[40] = 8'h80; mem[41] = 8'h7f;
    run(3'd2, 8'd40, 1'b0, de, bc);
    checks++; if (result !== 64'hffffffffffffff80) begin failures++; $display("FAIL sleb64_result got=%h exp=ffffffffffffff80", result); end
    checks++; if (pc_out !== 8'd42) begin failures++; $display("FAIL sleb64_pc_out got=%0d exp=42", pc_out); end
    mem[80] = 8'hff; mem[81] = 8'hff; mem[82] = 8'hff; mem[83] = 8'hff; mem[84] = 8'h0f;
    run(3'd0, 8'd80, 1'b0, de, bc);
    checks++; if (de !== 6) begin failures++; $display("FAIL uleb5_done_edge got=%0d exp=6", de); end
    checks++; if (result !== 64'h00000000ffffffff || error !== 1'b0) begin failures++; $display("FAIL uleb5_result got=%h err=%b exp=00000000ffffffff err=0", result, error); end
  endtask

  task automatic test_fix64_wrap();
    mem[48] = 8'h00; mem[49] = 8'h00; mem[50] = 8'h00; mem[51] = 8'h00;
    mem[52] = 8'h00; mem[53] = 8'h00; mem[54] = 8'hf0; mem[55] = 8'h3f;
    run(3'd4, 8'd48, 1'b0, de, bc);
    checks++; if (de !== 9) begin failures++; $display("FAIL fix64_done_edge got=%0d exp=9", de); end
    checks++; if (result !== 64'h3ff0000000000000) begin failures++; $display("FAIL fix64_result got=%h exp=3ff0000000000000", result); end
    checks++; if (pc_out !== 8'd56) begin failures++; $display("FAIL fix64_pc_out got=%0d exp=56", pc_out); end
    mem[254] = 8'h78; mem[255] = 8'h56; mem[0] = 8'h34; mem[1] = 8'h12;
    run(3'd3, 8'd254, 1'b0, de, bc);
    checks++; if (result !== 64'h0000000012345678) begin failures++; $display("FAIL wrap_result got=%h exp=0000000012345678", result); end
    checks++; if (pc_out !== 8'd2) begin failures++; $display("FAIL wrap_pc_out got=%0d exp=2", pc_out); end
  endtask

  task automatic test_errors();
    for (int i = 64; i < 70; i++) mem[i] = 8'h80;
    run(3'd0, 8'd64, 1'b0, de, bc);
    checks++; if (de !== 6) begin failures++; $display("FAIL len_err_done_edge got=%0d exp=6", de); end
    checks++; if (error !== 1'b1 || result !== 64'd0) begin failures++; $display("FAIL len_err_flags got err=%b res=%h exp err=1 res=0", error, result); end
    checks++; if (pc_out !== 8'd69) begin failures++; $display("FAIL len_err_pc_out got=%0d exp=69", pc_out); end
    mem[32] = 8'h7f;
    run(3'd1, 8'd32, 1'b0, de, bc);
    run(3'd6, 8'd77, 1'b0, de, bc);
    checks++; if (de !== 0 || bc !== 0) begin failures++; $display("FAIL rsv_timing got done_edge=%0d busy=%0d exp 0 0", de, bc); end
    checks++; if (error !== 1'b1 || result !== 64'd0 || pc_out !== 8'd77) begin failures++; $display("FAIL rsv_outputs got err=%b res=%h pc=%0d exp 1 0 77", error, result, pc_out); end
    run(3'd1, 8'd32, 1'b0, de, bc);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", error); end
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; kind = 3'd4; pc_in = 8'd48;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1; reset = 1'b1;
    #1;
    checks++; if ({result, pc_out, rom_addr} !== 80'd0) begin failures++; $display("FAIL midreset_values got res=%h pc=%0d addr=%0d exp 0", result, pc_out, rom_addr); end
    checks++; if ({busy, done, error} !== 3'b000) begin failures++; $display("FAIL midreset_flags got=%b exp=000", {busy, done, error}); end
    @(negedge clk); @(negedge clk); reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL midreset_no_done got=%b exp=0", saw_done); end
  endtask

  task automatic test_back_to_back();
    run(3'd0, 8'd16, 1'b1, de, bc);
    checks++; if (de !== 4) begin failures++; $display("FAIL hammer_done_edge got=%0d exp=4", de); end
    checks++; if (result !== 64'd624485 || pc_out !== 8'd19) begin failures++; $display("FAIL hammer_outputs got res=%h pc=%0d exp %h 19", result, pc_out, 64'd624485); end
    // done is high in this cycle; a start here must be dropped
    @(negedge clk); start = 1'b1; kind = 3'd0; pc_in = 8'd32;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_on_done_busy got=%b exp=0", busy); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (result !== 64'd624485 || done !== 1'b0) begin failures++; $display("FAIL start_on_done_result got res=%h done=%b exp %h 0", result, done, 64'd624485); end
    run(3'd0, 8'd32, 1'b0, de, bc);
    checks++; if (result !== 64'd127 || de !== 2) begin failures++; $display("FAIL retry_after_done got res=%h edge=%0d exp 7f 2", result, de); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_fix32();
    test_leb();
    test_fix64_wrap();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wasm_imm_decoder.md
Name: wasm_imm_decoder

Overview:
- Fetch unit that reads the immediate operand following an opcode out of bytecode ROM and decodes it into a 64-bit value ready for the operand stack.
- Handles LEB128 immediates (i32.const, i64.const, indices) and fixed little-endian IEEE754 immediates (f32.const, f64.const).
- Sits between the cpu fetch/dispatch FSM and the bytecode ROM; the cpu starts it with the PC just past the opcode and resumes at pc_out.

Parameters:
- ROM_ADDR, 8, width of the ROM byte address and of the pc_in/pc_out/rom_addr ports.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, request a decode; sampled only in IDLE.
- kind, input, 3, immediate format, latched on start: 0 ULEB32, 1 SLEB32, 2 SLEB64, 3 FIX32, 4 FIX64; 5-7 reserved.
- pc_in, input, ROM_ADDR, address of the first immediate byte, latched on start.
- rom_addr, output, ROM_ADDR, byte address presented to the synchronous ROM.
- rom_data, input, 8, ROM byte; valid one cycle after rom_addr.
- result, output, 64, decoded value; held until the next start.
- pc_out, output, ROM_ADDR, address of the first byte after the immediate.
- busy, output, 1, high from the edge after start until done.
- done, output, 1, one-cycle completion pulse.
- error, output, 1, held high with done when the encoding is malformed; cleared on the next start.

Behaviour:
- Reset (asynchronous): state IDLE; result=0, pc_out=0, rom_addr=0, busy=0, done=0, error=0, byte count=0, shift=0.
- States and transitions:
  - IDLE: on start with kind 0-4: latch kind, rom_addr<=pc_in, clear the accumulator, count and shift; go to PRIME. start with kind 5-7: go to IDLE and pulse done with error=1, result=0, pc_out=pc_in.
  - PRIME: rom_addr<=rom_addr+1 (address pipelining); go to ACC.
  - ACC: consume rom_data as byte index = count; rom_addr increments every cycle (overfetch of at most one byte is permitted).
  - FIX32/FIX64: acc |= byte << 8*count; complete after 4 or 8 bytes.
  - LEB kinds: acc |= byte[6:0] << shift; shift += 7; complete on the first byte with bit7=0.
- Latency:
  - start sampled at edge 0, N-byte immediate: done is high in the cycle after edge N+1 and is then deasserted.
  - busy is high for N+1 cycles.
  - Example: FIX32, done is visible after edge 5.
- On completion:
  - pc_out = pc_in + N.
  - result: FIX32 and ULEB32 are zero-extended into bits [63:32].
  - SLEB32: if bit6 of the final byte is set, sign-extend from bit shift+7 to bit 31, then force bits [63:32] to 0. The 32-bit stack convention keeps the upper half zero.
  - SLEB64: sign-extend from bit shift+7 to bit 63. No extension is applied when shift+7 ≥ 64.
  - FIX64: the raw 64 bits.
- Length errors: a continuation bit still set on byte 5 (32-bit kinds) or byte 10 (SLEB64) completes immediately with error=1, result=0, pc_out=pc_in+count+1.
- Non-canonical unused high bits in the last byte are not checked.
- start while busy is ignored; start in the same cycle as done is ignored, and the next start is honoured from IDLE.
- Reset asserted mid-decode aborts it. No done pulse follows, and outputs return to their reset values.
- pc arithmetic wraps modulo 2^ROM_ADDR.

Decomposition:
- Shared package holds: the kind encodings (IMM_ULEB32..IMM_FIX64), the state encodings, and the constants MAX_LEB32_BYTES=5 and MAX_LEB64_BYTES=10.
- Sub-module leb_sext: combinational sign-extend, taking (value, shift, is64) and returning a 64-bit value. It is shared with any future decoder for block types.
- Everything else stays in one module.

Test Plan:
- FIX32 at pc 4, ROM bytes 00 00 00 c0 -> done after edge 5; result=64'h00000000c0000000, pc_out=8, error=0, busy high for 5 cycles.
- ULEB32, bytes e5 8e 26 -> result=64'd624485, pc_out=pc_in+3, done after edge 4.
- SLEB32, byte 7f -> result=64'h00000000ffffffff. SLEB64, bytes 80 7f -> result=64'hffffffffffffff80, pc_out=pc_in+2.
- FIX64, bytes 00 00 00 00 00 00 f0 3f -> result=64'h3ff0000000000000, pc_out=pc_in+8. Also check pc wrap with pc_in=2^ROM_ADDR-2.
- ULEB32, six bytes of 80 -> done after edge 6 with error=1, result=0, pc_out=pc_in+5. kind=6 -> immediate error done.
- Reset asserted at edge 2 of a FIX64 decode -> all outputs 0 immediately, with no done pulse. start pulses while busy -> no effect on result, pc_out or done timing.
